// File: rtl/pe_array_pkg.sv
// Shared constants and flat-bus offset helper for the output-stationary MAC array.
package pe_array_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  // Bit offset of accumulator element k within the flat outs bus
  function automatic int acc_off(input int k);
    return k * ACC_W;
  endfunction

endpackage

// File: rtl/pe_array_mac.sv
// One processing element: operand pass registers plus a wrapping 32-bit accumulator.
module pe_mac
  import pe_array_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] w_out,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] w_q;

  // Unsigned product zero-extended; the sum wraps modulo 2^ACC_W
  function automatic logic [ACC_W-1:0] mac_wrap(input logic [ACC_W-1:0] sum,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] w);
    logic [2*DATA_W-1:0] prod;
    prod = a * w;
    return sum + ACC_W'(prod);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      w_q <= '0;
      acc <= '0;
    end else if (fire) begin
      a_q <= a_in;
      w_q <= w_in;
      acc <= mac_wrap(acc, a_in, w_in);
    end
  end

  assign a_out = a_q;
  assign w_out = w_q;

endmodule

// File: rtl/pe_array.sv
// ROWS x COLS systolic grid: activations flow right, weights flow down, sums stay put.
module pe_array
  import pe_array_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fire,
  input  logic [0:DATA_W*COLS-1]      in_w,
  input  logic [0:DATA_W*ROWS-1]      in_a,
  output logic [0:ACC_W*ROWS*COLS-1]  outs
);

  // a_lnk[r][c] feeds PE(r,c); w_lnk[r][c] likewise; the far edges fall off the array
  logic [DATA_W-1:0] a_lnk [ROWS][COLS+1];
  logic [DATA_W-1:0] w_lnk [ROWS+1][COLS];
  logic [DATA_W-1:0] unused_a [ROWS];
  logic [DATA_W-1:0] unused_w [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_left
    assign a_lnk[r][0] = in_a[DATA_W*r +: DATA_W];
    assign unused_a[r] = a_lnk[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign w_lnk[0][c] = in_w[DATA_W*c +: DATA_W];
    assign unused_w[c] = w_lnk[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int OFF = acc_off(r*COLS + c);
      logic [ACC_W-1:0] acc;

      pe_mac u_pe (
        .clk   (clk),
        .rst   (rst),
        .fire  (fire),
        .a_in  (a_lnk[r][c]),
        .w_in  (w_lnk[r][c]),
        .a_out (a_lnk[r][c+1]),
        .w_out (w_lnk[r+1][c]),
        .acc   (acc)
      );

      assign outs[OFF +: ACC_W] = acc;
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// Directed bench for pe_array: reset, pulse, streams, fire hold, max operands, matmul.
module tb_pe_array;

  localparam int R = 4;
  localparam int C = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               fire;
  logic [0:8*C-1]     in_w;
  logic [0:8*R-1]     in_a;
  logic [0:32*R*C-1]  outs;

  int tests = 0;
  int fails = 0;

  pe_array #(.ROWS(R), .COLS(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .fire (fire),
    .in_w (in_w),
    .in_a (in_a),
    .outs (outs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get(input int r, input int c);
    return outs[32*(r*C+c) +: 32];
  endfunction

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < R; i++) in_a[8*i +: 8] = v;
    for (int i = 0; i < C; i++) in_w[8*i +: 8] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_all(8'hFF);
    fire = 1'b1;
    rst  = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          tests++;
          if (get(r, c) !== 32'd0) begin
            fails++;
            $display("FAIL reset pe(%0d,%0d) got %0d want 0", r, c, get(r, c));
          end
        end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_pulse();
    logic [31:0] exp;
    set_all(8'd0);
    do_reset();
    in_a[0 +: 8] = 8'd3;
    in_w[0 +: 8] = 8'd5;
    fire = 1'b1;
    step();
    set_all(8'd0);
    for (int e = 0; e < 9; e++) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          exp = (r == 0 && c == 0) ? 32'd15 : 32'd0;
          tests++;
          if (get(r, c) !== exp) begin
            fails++;
            $display("FAIL pulse step%0d pe(%0d,%0d) got %0d want %0d", e, r, c, get(r, c), exp);
          end
        end
      step();
    end
  endtask

  task automatic test_constant_stream();
    logic [31:0] exp;
    set_all(8'd0);
    do_reset();
    set_all(8'd2);
    fire = 1'b1;
    repeat (10) step();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        exp = 32'(4 * (10 - ((r > c) ? r : c)));
        tests++;
        if (get(r, c) !== exp) begin
          fails++;
          $display("FAIL stream pe(%0d,%0d) got %0d want %0d", r, c, get(r, c), exp);
        end
      end
  endtask

  task automatic test_fire_hold();
    logic [31:0] base, exp;
    set_all(8'd0);
    do_reset();
    set_all(8'd2);
    fire = 1'b1;
    repeat (5) step();
    fire = 1'b0;
    set_all(8'd7);
    for (int e = 0; e < 6; e++) begin
      step();
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          exp = 32'(4 * (5 - ((r > c) ? r : c)));
          tests++;
          if (get(r, c) !== exp) begin
            fails++;
            $display("FAIL hold step%0d pe(%0d,%0d) got %0d want %0d", e, r, c, get(r, c), exp);
          end
        end
    end
    // Edge columns/rows take the new 7s, interior still sees the stalled 2s
    fire = 1'b1;
    step();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        base = 32'(4 * (5 - ((r > c) ? r : c)));
        exp  = base + ((c == 0) ? 32'd7 : 32'd2) * ((r == 0) ? 32'd7 : 32'd2);
        tests++;
        if (get(r, c) !== exp) begin
          fails++;
          $display("FAIL resume pe(%0d,%0d) got %0d want %0d", r, c, get(r, c), exp);
        end
      end
    fire = 1'b0;
  endtask

  task automatic test_max_operand();
    set_all(8'd0);
    do_reset();
    set_all(8'hFF);
    fire = 1'b1;
    repeat (8) step();
    tests++;
    if (get(0, 0) !== 32'd520200) begin
      fails++;
      $display("FAIL max pe(0,0) got %0d want 520200", get(0, 0));
    end
    tests++;
    if (get(3, 3) !== 32'd325125) begin
      fails++;
      $display("FAIL max pe(3,3) got %0d want 325125", get(3, 3));
    end
    tests++;
    if (get(1, 2) !== 32'd390150) begin
      fails++;
      $display("FAIL max pe(1,2) got %0d want 390150", get(1, 2));
    end
  endtask

  task automatic run_matmul(input logic [7:0] a [4][4], input logic [7:0] b [4][4]);
    int k;
    set_all(8'd0);
    do_reset();
    fire = 1'b1;
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < R; r++) begin
        k = t - r;
        in_a[8*r +: 8] = (k >= 0 && k < 4) ? a[r][k] : 8'd0;
      end
      for (int c = 0; c < C; c++) begin
        k = t - c;
        in_w[8*c +: 8] = (k >= 0 && k < 4) ? b[k][c] : 8'd0;
      end
      step();
    end
    set_all(8'd0);
    fire = 1'b0;
  endtask

  task automatic test_matmul_identity();
    logic [7:0] a [4][4];
    logic [7:0] b [4][4];
    logic [31:0] exp;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = (i == j) ? 8'd1 : 8'd0;
        b[i][j] = 8'(10*i + j);
      end
    run_matmul(a, b);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        exp = 32'(10*r + c);
        tests++;
        if (get(r, c) !== exp) begin
          fails++;
          $display("FAIL ident pe(%0d,%0d) got %0d want %0d", r, c, get(r, c), exp);
        end
      end
  endtask

  task automatic test_matmul_random();
    logic [7:0] a [4][4];
    logic [7:0] b [4][4];
    logic [31:0] exp;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a[i][j] = 8'($urandom_range(0, 255));
          b[i][j] = 8'($urandom_range(0, 255));
        end
      run_matmul(a, b);
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          exp = 32'd0;
          for (int kk = 0; kk < 4; kk++)
            exp = exp + 32'(a[r][kk]) * 32'(b[kk][c]);
          tests++;
          if (get(r, c) !== exp) begin
            fails++;
            $display("FAIL rand%0d pe(%0d,%0d) got %0d want %0d", n, r, c, get(r, c), exp);
          end
        end
    end
  endtask

  initial begin
    rst  = 1'b0;
    fire = 1'b0;
    in_a = '0;
    in_w = '0;
    test_reset();
    test_single_pulse();
    test_constant_stream();
    test_fire_hold();
    test_max_operand();
    test_matmul_identity();
    test_matmul_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_array.md
Name: pe_array

Overview:
- Output-stationary systolic MAC array of ROWS x COLS processing elements (PEs) for 8-bit unsigned matrix multiply.
- Activations enter on the left edge, one per row, and shift right one PE per cycle.
- Weights enter on the top edge, one per column, and shift down one PE per cycle.
- Each PE accumulates activation*weight into a 32-bit register exposed on a flat output bus; input skewing and result readout are the caller's responsibility.

Parameters:
- rows, 4, number of PE rows; one activation lane per row.
- cols, 4, number of PE columns; one weight lane per column.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fire  input  1  global advance enable; when low, all state holds.
- in_w  input  8*cols  weight lanes; lane c occupies bits [8c : 8c+7], ascending-index vector, MSB at lowest index.
- in_a  input  8*rows  activation lanes; lane r occupies bits [8r : 8r+7], same ordering.
- outs  output  32*rows*cols  accumulators; PE(r,c) is element k = r*cols+c at bits [32k : 32k+31], MSB at lowest index.

Behaviour:
- Reset (Already decided): one clock; reset is synchronous and active-high.
  - rst high at a rising edge clears every accumulator and every a/w pass register to 0.
  - outs reads all zero from the following cycle.
  - rst has priority over fire.
  - Reset mid-operation discards all partial sums and in-flight operands.
- Each PE holds three registers: a_q (8b), w_q (8b), acc (32b).
- PE inputs:
  - a_in = in_a[r] when c==0, else a_q of PE(r,c-1).
  - w_in = w_in_top = in_w[c] when r==0, else w_q of PE(r-1,c).
- On a rising edge with rst=0 and fire=1:
  - a_q <= a_in
  - w_q <= w_in
  - acc <= acc + a_in*w_in
- On a rising edge with rst=0 and fire=0, every register holds; fire freezes the whole array, including the pass pipeline.
- Arithmetic:
  - Operands are unsigned 8-bit; the product is 16-bit, zero-extended to 32 bits.
  - acc wraps modulo 2^32 with no saturation and no overflow flag.
- Timing:
  - PE(r,c) multiplies in_a[r] from c fire-cycles earlier by in_w[c] from r fire-cycles earlier.
  - The product is visible on outs one cycle after that edge.
  - PE(0,0) has latency 1.
- Matmul usage: drive in_a[r] = A[r][k] at fire-cycle k+r and in_w[c] = B[k][c] at fire-cycle k+c, with zeros elsewhere.
  - C[r][c] is complete after fire-cycle (K-1)+r+c.
  - The full result is valid K+rows+cols-2 fire-cycles after the first input.
- outs is driven directly from the acc registers; there is no combinational path from inputs to outs.

Decomposition:
- Shared package holds the constants DATA_W=8 and ACC_W=32, plus the helper function computing a flat-bus slice offset for element k.
- One sub-module, pe_mac: holds a_q, w_q and acc, exposes a_out, w_out and acc.
- pe_array is a 2-D generate of pe_mac instances plus bus slicing.

Test Plan:
- Reset: all inputs 0x FF, fire=1, rst=1 for 2 cycles -> every outs element 0; no element changes while rst is held.
- Single pulse: in_a[0]=3, in_w[0]=5 for one fire cycle, then zeros -> PE(0,0)=15 one cycle later; all other PEs stay 0 for 8 further cycles.
- Constant stream: after reset, all lanes =2 with fire=1 for 10 edges -> PE(r,c)=4*(10-max(r,c)); e.g. PE(0,0)=40, PE(3,3)=28, PE(1,3)=28.
- Fire hold: run the constant stream for 5 edges, drop fire for 6 edges while changing inputs to 7 -> outs unchanged during the hold.
  - Re-raise fire: accumulation resumes using the pipelined 2s first.
- Max operand: all lanes 255 for 8 edges -> PE(0,0)=8*65025=520200, confirming a 16-bit product into a 32-bit accumulator.
- Matmul: skewed 4x4 inputs with A=identity, B[k][c]=10k+c -> after 10 fire cycles outs equals B row-major (0,1,2,3,10,...,33).
  - Repeat with random A and B against a golden model; compare each element as unsigned 32-bit.
